// File: rtl/conv_stage_sched.sv
// Purpose: per-sample sequencer that walks the allocation list and drives regfile, data/coef RAM and MAC (S1..S8).
// Latency: input accepted in S7; per entry 2 (fetch) + 2 (S2) + vector_len + MAC_LAT-1 + 1..3 write/output cycles + 1 (S8).
// Backpressure: in_ready low whenever busy; S6 holds out_valid until out_ready, stalling the whole list walk.
//
// Ports: clk/rst_n (async active-low); list_last = last allocation index (sampled in S8 only);
//   ps_addr/ps_rdata = allocation list (1-cycle synchronous read);
//   in_valid/in_ready = audio sample in; out_valid/out_ready = system output;
//   regf_* = register file control; dram_*/coef_addr = RAM addresses; mac_* = MAC control; busy = not idle.
// Optional: define CONV_SCHED_OVR_EN to add sticky 'overrun' (in_valid seen while busy).
module conv_stage_sched #(
    parameter int VEC_ID_W       = 5,
    parameter int REGFILE_ADDR_W = 4,
    parameter int ALLOC_LEN_W    = 8,
    parameter int DATA_ADDR_W    = 10,
    parameter int PS_ADDR_W      = 5,
    parameter int IN_REG         = 0,
    parameter int MAC_LAT        = 2,
    parameter int ENTRY_W        = 2 + VEC_ID_W + 2*REGFILE_ADDR_W + ALLOC_LEN_W + 2*DATA_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PS_ADDR_W-1:0]      list_last,
    output logic [PS_ADDR_W-1:0]      ps_addr,
    input  logic [ENTRY_W-1:0]        ps_rdata,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REGFILE_ADDR_W-1:0] regf_raddr,
    output logic [REGFILE_ADDR_W-1:0] regf_waddr,
    output logic                      regf_we,
    output logic [1:0]                regf_wsel,
    output logic [DATA_ADDR_W-1:0]    dram_addr,
    output logic                      dram_we,
    output logic [DATA_ADDR_W-1:0]    coef_addr,
    output logic                      mac_clr,
    output logic                      mac_en,
    output logic                      mac_last,
`ifdef CONV_SCHED_OVR_EN
    output logic                      overrun,
`endif
    output logic                      busy
);

    // Entry field offsets, LSB first: coef_ptr, data_ptr, vector_len, error_reg, result_reg, vector_id, upse_f, lstg_f
    localparam int DP_LO = DATA_ADDR_W;
    localparam int VL_LO = 2*DATA_ADDR_W;
    localparam int ER_LO = VL_LO + ALLOC_LEN_W;
    localparam int RR_LO = ER_LO + REGFILE_ADDR_W;
    localparam int VI_LO = RR_LO + REGFILE_ADDR_W;
    localparam int UP_BIT = VI_LO + VEC_ID_W;
    localparam int LS_BIT = UP_BIT + 1;

    typedef enum logic [2:0] {S7, S1, S2, S3, S4, S5, S6, S8} state_t;

    state_t                    state, state_nx;
    logic                      sub, sub_nx;       // second cycle of S1/S2, MAC drain phase of S3
    logic [ALLOC_LEN_W-1:0]    cnt, cnt_nx;       // k in S3 mac phase, drain cycles in S3 wait phase
    logic [PS_ADDR_W-1:0]      asc;
    logic [REGFILE_ADDR_W-1:0] src_reg;

    logic                      lstg_f, upse_f;
    logic [REGFILE_ADDR_W-1:0] result_reg, error_reg;
    logic [ALLOC_LEN_W-1:0]    vector_len;
    logic [DATA_ADDR_W-1:0]    data_ptr, coef_ptr;

    // vector_id is carried by the list for software only; nothing here consumes it
    logic unused_vec_id;
    assign unused_vec_id = ^ps_rdata[UP_BIT-1:VI_LO];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S7;
            sub        <= 1'b0;
            cnt        <= '0;
            asc        <= '0;
            src_reg    <= REGFILE_ADDR_W'(IN_REG);
            lstg_f     <= 1'b0;
            upse_f     <= 1'b0;
            result_reg <= '0;
            error_reg  <= '0;
            vector_len <= '0;
            data_ptr   <= '0;
            coef_ptr   <= '0;
        end else begin
            state <= state_nx;
            sub   <= sub_nx;
            cnt   <= cnt_nx;
            // second S1 cycle: read data for ps_addr issued last cycle is now valid
            if (state == S1 && sub) begin
                lstg_f     <= ps_rdata[LS_BIT];
                upse_f     <= ps_rdata[UP_BIT];
                result_reg <= ps_rdata[RR_LO +: REGFILE_ADDR_W];
                error_reg  <= ps_rdata[ER_LO +: REGFILE_ADDR_W];
                vector_len <= ps_rdata[VL_LO +: ALLOC_LEN_W];
                data_ptr   <= ps_rdata[DP_LO +: DATA_ADDR_W];
                coef_ptr   <= ps_rdata[0 +: DATA_ADDR_W];
            end
            // the next stage consumes this stage's result
            if (state == S4)
                src_reg <= result_reg;
            if (state == S8) begin
                if (asc == list_last) begin
                    asc     <= '0;
                    src_reg <= REGFILE_ADDR_W'(IN_REG);
                end else begin
                    asc <= asc + 1'b1;
                end
            end
        end
    end

`ifdef CONV_SCHED_OVR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (in_valid && busy)
            overrun <= 1'b1;
    end
`endif

    always_comb begin
        state_nx   = state;
        sub_nx     = sub;
        cnt_nx     = cnt;
        ps_addr    = '0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        regf_raddr = '0;
        regf_waddr = '0;
        regf_we    = 1'b0;
        regf_wsel  = 2'd0;
        dram_addr  = '0;
        dram_we    = 1'b0;
        coef_addr  = '0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        mac_last   = 1'b0;
        busy       = 1'b1;
        case (state)
            S7: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    regf_we    = 1'b1;
                    regf_waddr = REGFILE_ADDR_W'(IN_REG);
                    regf_wsel  = 2'd0;
                    state_nx   = S1;
                    sub_nx     = 1'b0;
                end
            end
            S1: begin
                ps_addr = asc;
                sub_nx  = !sub;
                if (sub)
                    state_nx = S2;
            end
            S2: begin
                if (!sub) begin
                    regf_raddr = src_reg;
                    sub_nx     = 1'b1;
                end else begin
                    dram_we   = 1'b1;
                    dram_addr = data_ptr;
                    mac_clr   = 1'b1;
                    sub_nx    = 1'b0;
                    cnt_nx    = '0;
                    // empty vector: the cleared accumulator is the result
                    state_nx  = (vector_len == '0) ? S4 : S3;
                end
            end
            S3: begin
                if (!sub) begin
                    mac_en    = 1'b1;
                    dram_addr = data_ptr + DATA_ADDR_W'(cnt);
                    coef_addr = coef_ptr + DATA_ADDR_W'(cnt);
                    if (cnt == vector_len - 1'b1) begin
                        mac_last = 1'b1;
                        cnt_nx   = '0;
                        // S4 lands exactly MAC_LAT cycles after the last operand
                        if (MAC_LAT <= 1)
                            state_nx = S4;
                        else
                            sub_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    if (cnt == ALLOC_LEN_W'(MAC_LAT - 2)) begin
                        state_nx = S4;
                        sub_nx   = 1'b0;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            S4: begin
                regf_we    = 1'b1;
                regf_waddr = result_reg;
                regf_wsel  = 2'd1;
                state_nx   = upse_f ? S5 : (lstg_f ? S6 : S8);
            end
            S5: begin
                regf_we    = 1'b1;
                regf_waddr = error_reg;
                regf_wsel  = 2'd2;
                state_nx   = lstg_f ? S6 : S8;
            end
            S6: begin
                regf_raddr = result_reg;
                out_valid  = 1'b1;
                if (out_ready)
                    state_nx = S8;
            end
            S8: begin
                state_nx = (asc == list_last) ? S7 : S1;
            end
            default: state_nx = S7;
        endcase
    end

endmodule

// File: tb/tb_conv_stage_sched.sv
module tb_conv_stage_sched;

    localparam int EW = 43;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    list_last = '0;
    logic [4:0]    ps_addr;
    logic [EW-1:0] ps_rdata = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    regf_raddr, regf_waddr;
    logic          regf_we;
    logic [1:0]    regf_wsel;
    logic [9:0]    dram_addr, coef_addr;
    logic          dram_we, mac_clr, mac_en, mac_last, busy;
`ifdef CONV_SCHED_OVR_EN
    logic          overrun;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [EW-1:0] prog [0:31];

    conv_stage_sched dut (
        .clk(clk), .rst_n(rst_n), .list_last(list_last),
        .ps_addr(ps_addr), .ps_rdata(ps_rdata),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .regf_raddr(regf_raddr), .regf_waddr(regf_waddr), .regf_we(regf_we), .regf_wsel(regf_wsel),
        .dram_addr(dram_addr), .dram_we(dram_we), .coef_addr(coef_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last),
`ifdef CONV_SCHED_OVR_EN
        .overrun(overrun),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // program store: synchronous read, one cycle latency
    always @(posedge clk) ps_rdata <= prog[ps_addr];

    // event word: {kind, a, b, c}
    localparam int K_WR = 1, K_CLR = 2, K_MAC = 3, K_OUT = 4;
    function automatic logic [31:0] ev(input int k, input int a, input int b, input int c);
        return {4'(k), 12'(a), 12'(b), 4'(c)};
    endfunction

    function automatic logic [EW-1:0] mk_entry(input int lstg, input int upse, input int res,
                                               input int err, input int len, input int dp, input int cp);
        return {1'(lstg), 1'(upse), 5'd0, 4'(res), 4'(err), 8'(len), 10'(dp), 10'(cp)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // monitor: turns DUT activity into events and checks them against the scoreboard
    logic [3:0] prev_raddr = '0;
    int         since_ref = 0;
    always @(negedge clk) begin
        logic [31:0] obs[$];
        if (rst_n) begin
            obs = {};
            since_ref++;
            if (regf_we)
                obs.push_back(ev(K_WR, int'(regf_waddr), int'(regf_wsel), (regf_wsel == 2'd1) ? since_ref : 0));
            if (mac_clr)
                obs.push_back(ev(K_CLR, int'(prev_raddr), int'(dram_addr), int'(dram_we)));
            if (mac_en)
                obs.push_back(ev(K_MAC, int'(dram_addr), int'(coef_addr), int'(mac_last)));
            if (out_valid && out_ready)
                obs.push_back(ev(K_OUT, int'(regf_raddr), 0, 0));
            foreach (obs[i]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: got %h expected none", obs[i]);
                end else begin
                    chk("event", obs[i], exp_q.pop_front());
                end
            end
            if (mac_clr || mac_last) since_ref = 0;
            prev_raddr = regf_raddr;
        end
    end

    task automatic send_sample();
        @(posedge clk); #1 in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin @(negedge clk); n++; end
        n_checks++;
        if (!busy) n_pass++;
        else $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, n);
    endtask

    task automatic push_test_a();
        exp_q.push_back(ev(K_WR, 0, 0, 0));
        exp_q.push_back(ev(K_CLR, 0, 1022, 1));
        exp_q.push_back(ev(K_MAC, 1022, 8, 0));
        exp_q.push_back(ev(K_MAC, 1023, 9, 0));
        exp_q.push_back(ev(K_MAC, 0, 10, 0));
        exp_q.push_back(ev(K_MAC, 1, 11, 1));
        exp_q.push_back(ev(K_WR, 5, 1, 2));
        exp_q.push_back(ev(K_OUT, 5, 0, 0));
    endtask

    task automatic set_prog_a();
        list_last = 5'd0;
        prog[0] = mk_entry(1, 0, 5, 0, 4, 1022, 8);
    endtask

    task automatic set_prog_b();
        list_last = 5'd1;
        prog[0] = mk_entry(0, 1, 3, 7, 2, 100, 200);
        prog[1] = mk_entry(1, 0, 9, 0, 0, 50, 60);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) prog[i] = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_regf_we", 32'(regf_we), 32'd0);
        chk("rst_mac_en", 32'(mac_en), 32'd0);
        chk("rst_ps_addr", 32'(ps_addr), 32'd0);
`ifdef CONV_SCHED_OVR_EN
        chk("rst_overrun", 32'(overrun), 32'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_dram_addr", 32'(dram_addr), 32'd0);

        // single entry, data pointer wraps at 1023 -> 0
        set_prog_a();
        push_test_a();
        send_sample();
        wait_idle("test_a");

        // two entries: upsampling error write, then chained source register, empty vector
        set_prog_b();
        exp_q.push_back(ev(K_WR, 0, 0, 0));
        exp_q.push_back(ev(K_CLR, 0, 100, 1));
        exp_q.push_back(ev(K_MAC, 100, 200, 0));
        exp_q.push_back(ev(K_MAC, 101, 201, 1));
        exp_q.push_back(ev(K_WR, 3, 1, 2));
        exp_q.push_back(ev(K_WR, 7, 2, 0));
        exp_q.push_back(ev(K_CLR, 3, 50, 1));
        exp_q.push_back(ev(K_WR, 9, 1, 1));
        exp_q.push_back(ev(K_OUT, 9, 0, 0));
        send_sample();
        wait_idle("test_b");

        // output stall: out_ready low for 10 cycles, inputs refused meanwhile
        set_prog_a();
        push_test_a();
        @(posedge clk); #1 out_ready = 1'b0;
        send_sample();
        begin
            int n = 0;
            @(negedge clk);
            while (!out_valid && n < 200) begin @(negedge clk); n++; end
            chk("stall_reach_s6", 32'(out_valid), 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 in_valid = 1'b1;
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_regf_raddr", 32'(regf_raddr), 32'd5);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        wait_idle("test_stall");
`ifdef CONV_SCHED_OVR_EN
        chk("overrun_set", 32'(overrun), 32'd1);
`endif

        // reset while in S3 at k=3: no further MAC step and no result write
        exp_q.push_back(ev(K_WR, 0, 0, 0));
        exp_q.push_back(ev(K_CLR, 0, 1022, 1));
        exp_q.push_back(ev(K_MAC, 1022, 8, 0));
        exp_q.push_back(ev(K_MAC, 1023, 9, 0));
        exp_q.push_back(ev(K_MAC, 0, 10, 0));
        send_sample();
        begin
            int n = 0;
            @(negedge clk);
            while (!(mac_en && dram_addr == 10'd0) && n < 200) begin @(negedge clk); n++; end
            chk("reach_k2", 32'(mac_en), 32'd1);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_mac_en", 32'(mac_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
`ifdef CONV_SCHED_OVR_EN
        chk("overrun_cleared", 32'(overrun), 32'd0);
`endif
        chk("mid_rst_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // after the abort the list restarts from entry 0 with src_reg = IN_REG
        set_prog_b();
        exp_q.push_back(ev(K_WR, 0, 0, 0));
        exp_q.push_back(ev(K_CLR, 0, 100, 1));
        exp_q.push_back(ev(K_MAC, 100, 200, 0));
        exp_q.push_back(ev(K_MAC, 101, 201, 1));
        exp_q.push_back(ev(K_WR, 3, 1, 2));
        exp_q.push_back(ev(K_WR, 7, 2, 0));
        exp_q.push_back(ev(K_CLR, 3, 50, 1));
        exp_q.push_back(ev(K_WR, 9, 1, 1));
        exp_q.push_back(ev(K_OUT, 9, 0, 0));
        send_sample();
        wait_idle("test_after_rst");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
